// File: rtl/wear_level_allocator_mc_if.sv
// Allocation/free bus between the flash controller requesters and the wear-levelling allocator.
interface wear_level_allocator_mc_if #(
  parameter int BLOCKS   = 64,
  parameter int CHANNELS = 2
);
  localparam int BW = $clog2(BLOCKS);

  logic [CHANNELS-1:0] alloc_req;
  logic [CHANNELS-1:0] alloc_gnt;
  logic [CHANNELS-1:0] alloc_fail;
  logic [BW-1:0]       alloc_block;
  logic                free_valid;
  logic [BW-1:0]       free_block;
  logic                free_err;
  logic [BW:0]         free_count;
  logic                wl_alert;
  logic                busy;

  modport master (
    output alloc_req, free_valid, free_block,
    input  alloc_gnt, alloc_fail, alloc_block, free_err, free_count, wl_alert, busy
  );

  modport slave (
    input  alloc_req, free_valid, free_block,
    output alloc_gnt, alloc_fail, alloc_block, free_err, free_count, wl_alert, busy
  );
endinterface

// File: rtl/wear_level_allocator_mc.sv
// Multi-channel wear-levelling allocator: round-robin requester pick, linear scan for the
// least-erased free block, erase-count/free-bitmap ownership and wear imbalance flag.
module wear_level_allocator_mc #(
  parameter int BLOCKS    = 64,
  parameter int ERASE_W   = 16,
  parameter int CHANNELS  = 2,
  parameter int THRESHOLD = 1000
) (
  input  logic clk,
  input  logic reset,
  wear_level_allocator_mc_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for any alloc_req; picks channel round-robin from rr
  // SCAN  | one block per cycle, tracking least-erased free block and min/max count
  // GRANT | result pulse visible; table, free_count, wl_alert and rr update at its end
  localparam int BW = $clog2(BLOCKS);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BLOCKS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;
  state_t state, state_nxt;

  logic [ERASE_W-1:0]  cnt [BLOCKS];
  logic [BLOCKS-1:0]   free_bits;
  logic [BW:0]         free_cnt;
  logic [CW-1:0]       rr, ch;
  logic [BW-1:0]       scan_idx, best_idx, blk;
  logic                best_found;
  logic [ERASE_W-1:0]  best_cnt, min_cnt, max_cnt;
  logic [CHANNELS-1:0] gnt, fail;
  logic                err, alert;

  logic                  any_req, start, scan_en, grant_en, busy, scan_last;
  logic [2*CHANNELS-1:0] req_rot;
  logic [CW:0]           off, pick_sum;
  logic [CW-1:0]         pick;
  logic [ERASE_W-1:0]    cur_cnt, nxt_min, nxt_max, nxt_best_cnt, spread;
  logic                  cur_free, take, nxt_found, free_ok, free_dup;
  logic [BW-1:0]         nxt_best_idx;

  // Round-robin: rotate requests so the rr channel sits at bit 0, take the first set bit.
  always_comb begin
    any_req = |bus.alloc_req;
    req_rot = {bus.alloc_req, bus.alloc_req} >> rr;
    off = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (req_rot[k]) off = (CW+1)'(k);
    end
    pick_sum = {1'b0, rr} + off;
    if (pick_sum >= (CW+1)'(CHANNELS)) pick_sum = pick_sum - (CW+1)'(CHANNELS);
    pick = pick_sum[CW-1:0];
  end

  always_comb begin
    cur_cnt      = cnt[scan_idx];
    cur_free     = free_bits[scan_idx];
    scan_last    = (scan_idx == LAST_IDX);
    take         = cur_free && (!best_found || (cur_cnt < best_cnt));
    nxt_found    = best_found || cur_free;
    nxt_best_idx = take ? scan_idx : best_idx;
    nxt_best_cnt = take ? cur_cnt : best_cnt;
    if (scan_idx == '0) begin
      nxt_min = cur_cnt;
      nxt_max = cur_cnt;
    end else begin
      nxt_min = (cur_cnt < min_cnt) ? cur_cnt : min_cnt;
      nxt_max = (cur_cnt > max_cnt) ? cur_cnt : max_cnt;
    end
    free_dup = bus.free_valid && free_bits[bus.free_block];
    free_ok  = bus.free_valid && !free_bits[bus.free_block];
    spread   = max_cnt - min_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = GRANT;
      GRANT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) && any_req;
    scan_en  = (state == SCAN);
    grant_en = (state == GRANT);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BLOCKS; i++) cnt[i] <= '0;
      free_bits  <= '1;
      free_cnt   <= (BW+1)'(BLOCKS);
      rr         <= '0;
      ch         <= '0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_found <= 1'b0;
      best_cnt   <= '0;
      min_cnt    <= '0;
      max_cnt    <= '0;
      gnt        <= '0;
      fail       <= '0;
      blk        <= '0;
      err        <= 1'b0;
      alert      <= 1'b0;
    end else begin
      gnt  <= '0;
      fail <= '0;
      err  <= free_dup;
      if (free_ok) begin
        free_bits[bus.free_block] <= 1'b1;
        if (cnt[bus.free_block] != '1) cnt[bus.free_block] <= cnt[bus.free_block] + 1'b1;
      end
      if (start) begin
        ch         <= pick;
        scan_idx   <= '0;
        best_found <= 1'b0;
      end
      if (scan_en) begin
        scan_idx   <= scan_idx + 1'b1;
        best_found <= nxt_found;
        best_idx   <= nxt_best_idx;
        best_cnt   <= nxt_best_cnt;
        min_cnt    <= nxt_min;
        max_cnt    <= nxt_max;
        if (scan_last) begin
          if (nxt_found) begin
            gnt <= CHANNELS'(1) << ch;
            blk <= nxt_best_idx;
          end else begin
            fail <= CHANNELS'(1) << ch;
          end
        end
      end
      // The granted block stays free through GRANT so a free of it there is a duplicate.
      if (grant_en) begin
        if (best_found) free_bits[best_idx] <= 1'b0;
        alert <= 32'(spread) > THRESHOLD;
        rr    <= (ch == CW'(CHANNELS - 1)) ? '0 : ch + 1'b1;
      end
      free_cnt <= free_cnt + (BW+1)'(free_ok) - (BW+1)'(grant_en && best_found);
    end
  end

  assign bus.alloc_gnt   = gnt;
  assign bus.alloc_fail  = fail;
  assign bus.alloc_block = blk;
  assign bus.free_err    = err;
  assign bus.free_count  = free_cnt;
  assign bus.wl_alert    = alert;
  assign bus.busy        = busy;
endmodule
